// File: rtl/bus_pkg.sv
// Shared constants and helpers for the bus terminal.
// Destination ID occupies the top ID_W bits of every packet.
package bus_pkg;

  localparam int ID_W = 8;

  // Widest packet the destination-slice helper accepts.
  localparam int PKT_MAX_W = 256;

  localparam logic [ID_W-1:0] BROADCAST_ID = {ID_W{1'b1}};

  // Extract the destination ID from a packet of width pkt_w held
  // right-justified in a PKT_MAX_W-bit vector.
  function automatic logic [ID_W-1:0] dest_id(input logic [PKT_MAX_W-1:0] pkt,
                                              input int unsigned pkt_w);
    logic [PKT_MAX_W-1:0] shifted;
    shifted = pkt >> (pkt_w - ID_W);
    return shifted[ID_W-1:0];
  endfunction

endpackage

// File: rtl/bus_fifo.sv
// First-word-fall-through FIFO used for both terminal queues.
// dout shows the head whenever empty is low. A read on an empty FIFO
// is ignored; a write to a full FIFO is accepted only if a read frees
// the slot in the same cycle. Synchronous active-low reset.
module bus_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [width-1:0]           din,
  output logic [width-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth):0]     count
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem_r [depth];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             rd_en_s;
  logic             wr_en_s;

  assign rd_en_s = rd && (count_r != CW'(0));
  assign wr_en_s = wr && ((count_r != CW'(depth)) || rd_en_s);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; writes are suppressed during reset so nothing leaks through.
  always_ff @(posedge clk) begin
    if (reset && wr_en_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(depth));
  assign empty = (count_r == CW'(0));
  assign count = count_r;

endmodule

// File: rtl/bus_terminal.sv
// Bus terminal: a host-side TX queue requesting the bus arbiter and an
// RX queue receiving packets the arbiter delivers.
// Optional feature macro: BUS_TERMINAL_ADDR_FILTER_EN -- when defined,
// only pushes addressed to `id` or to `broadcast` are accepted; when
// undefined, every push is accepted.
module bus_terminal
  import bus_pkg::*;
#(
  parameter int              pckg_sz   = 16,
  parameter int              depth     = 8,
  parameter int              id        = 0,
  parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_valid,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_ready,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  output logic [7:0]         ovf_cnt,
  output logic               err_pop
);

  localparam int CW = $clog2(depth) + 1;

  logic [CW-1:0] tx_count_s;
  logic [CW-1:0] rx_count_s;
  logic          tx_full_s;
  logic          tx_empty_s;
  logic          rx_full_s;
  logic          rx_empty_s;
  logic          tx_wr_s;
  logic          tx_rd_s;
  logic          rx_wr_s;
  logic          rx_rd_s;
  logic          addr_ok_s;
  logic          rx_room_s;
  logic [7:0]    ovf_cnt_r;
  logic          err_pop_r;
  logic          unused_ok_s;

`ifdef BUS_TERMINAL_ADDR_FILTER_EN
  logic [ID_W-1:0] push_dest_s;
  assign push_dest_s = dest_id(PKT_MAX_W'(D_push), pckg_sz);
  assign addr_ok_s   = (push_dest_s == ID_W'(id)) || (push_dest_s == broadcast);
`else
  assign addr_ok_s   = 1'b1;
`endif

  // Host side: tx_ready comes straight from the registered occupancy.
  assign tx_ready = (tx_count_s < CW'(depth));
  assign tx_wr_s  = tx_valid && tx_ready;
  assign tx_rd_s  = pop && !tx_empty_s;
  assign pndng    = !tx_empty_s;

  // Bus side: a full RX queue still takes a packet if the host reads now.
  assign rx_rd_s   = rx_ready && !rx_empty_s;
  assign rx_room_s = !rx_full_s || rx_rd_s;
  assign rx_wr_s   = push && addr_ok_s && rx_room_s;
  assign rx_valid  = !rx_empty_s;

  assign unused_ok_s = ^{tx_full_s, rx_count_s};

  bus_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_wr_s),
    .rd    (tx_rd_s),
    .din   (tx_data),
    .dout  (D_pop),
    .full  (tx_full_s),
    .empty (tx_empty_s),
    .count (tx_count_s)
  );

  bus_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_wr_s),
    .rd    (rx_rd_s),
    .din   (D_push),
    .dout  (rx_data),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .count (rx_count_s)
  );

  // Count accepted pushes lost to a full RX queue, saturating at 255.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_cnt_r <= 8'd0;
    end else if (push && addr_ok_s && !rx_room_s && (ovf_cnt_r != 8'd255)) begin
      ovf_cnt_r <= ovf_cnt_r + 8'd1;
    end
  end

  // Sticky flag for an arbiter pop against an empty TX queue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_pop_r <= 1'b0;
    end else if (pop && tx_empty_s) begin
      err_pop_r <= 1'b1;
    end
  end

  assign ovf_cnt = ovf_cnt_r;
  assign err_pop = err_pop_r;

endmodule

// File: tb/tb_bus_terminal.sv
// Directed testbench for bus_terminal (pckg_sz=16, depth=8, id=3).
module tb_bus_terminal;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready;
  logic [7:0]  ovf_cnt;
  logic        err_pop;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bus_terminal #(.pckg_sz(16), .depth(8), .id(3)) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .ovf_cnt(ovf_cnt), .err_pop(err_pop)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    tx_valid = 1'b0; tx_data = 16'h0000; pop = 1'b0;
    push = 1'b0; D_push = 16'h0000; rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    vectors++;
    if ({tx_ready, pndng, rx_valid, err_pop} !== 4'b1000) begin
      $display("FAIL reset_flags got=%b exp=1000", {tx_ready, pndng, rx_valid, err_pop});
      miscompares++;
    end
    vectors++;
    if (ovf_cnt !== 8'd0) begin
      $display("FAIL reset_ovf got=%0d exp=0", ovf_cnt);
      miscompares++;
    end
  endtask

  task automatic test_tx_fwft;
    tx_valid = 1'b1; tx_data = 16'h0155; tick();
    vectors++;
    if (pndng !== 1'b1 || D_pop !== 16'h0155) begin
      $display("FAIL tx_first pndng=%b D_pop=%h exp 1/0155", pndng, D_pop);
      miscompares++;
    end
    tx_data = 16'h0266; tick();
    tx_valid = 1'b0;
    vectors++;
    if (D_pop !== 16'h0155) begin
      $display("FAIL tx_hold D_pop=%h exp 0155", D_pop);
      miscompares++;
    end
    pop = 1'b1; tick(); pop = 1'b0;
    vectors++;
    if (pndng !== 1'b1 || D_pop !== 16'h0266) begin
      $display("FAIL tx_second pndng=%b D_pop=%h exp 1/0266", pndng, D_pop);
      miscompares++;
    end
    pop = 1'b1; tick(); pop = 1'b0;
    vectors++;
    if (pndng !== 1'b0 || err_pop !== 1'b0) begin
      $display("FAIL tx_drained pndng=%b err_pop=%b exp 0/0", pndng, err_pop);
      miscompares++;
    end
  endtask

  task automatic test_tx_full;
    for (int i = 0; i < 8; i++) begin
      tx_valid = 1'b1; tx_data = 16'h0A00 + 16'(i); tick();
    end
    vectors++;
    if (tx_ready !== 1'b0) begin
      $display("FAIL tx_full_ready got=%b exp=0", tx_ready);
      miscompares++;
    end
    tx_data = 16'h0BAD; tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (pndng !== 1'b1 || D_pop !== 16'h0A00 + 16'(i)) begin
        $display("FAIL tx_full_order[%0d] pndng=%b D_pop=%h exp 1/%h", i, pndng, D_pop, 16'h0A00 + 16'(i));
        miscompares++;
      end
      pop = 1'b1; tick(); pop = 1'b0;
    end
    vectors++;
    if (pndng !== 1'b0 || tx_ready !== 1'b1) begin
      $display("FAIL tx_full_empty pndng=%b tx_ready=%b exp 0/1", pndng, tx_ready);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back;
    tx_valid = 1'b1; tx_data = 16'h1111; tick();
    tx_data = 16'h2222; pop = 1'b1; tick();
    tx_valid = 1'b0; pop = 1'b0;
    vectors++;
    if (pndng !== 1'b1 || D_pop !== 16'h2222) begin
      $display("FAIL b2b_head pndng=%b D_pop=%h exp 1/2222", pndng, D_pop);
      miscompares++;
    end
    pop = 1'b1; tick(); pop = 1'b0;
    vectors++;
    if (pndng !== 1'b0) begin
      $display("FAIL b2b_empty pndng=%b exp 0", pndng);
      miscompares++;
    end
  endtask

  task automatic test_filter;
    logic [15:0] exp_q [$];
`ifdef BUS_TERMINAL_ADDR_FILTER_EN
    exp_q = '{16'h03AA, 16'hFFCC};
`else
    exp_q = '{16'h03AA, 16'h04BB, 16'hFFCC};
`endif
    push = 1'b1;
    D_push = 16'h03AA; tick();
    D_push = 16'h04BB; tick();
    D_push = 16'hFFCC; tick();
    push = 1'b0;
    foreach (exp_q[i]) begin
      vectors++;
      if (rx_valid !== 1'b1 || rx_data !== exp_q[i]) begin
        $display("FAIL filter_seq[%0d] rx_valid=%b rx_data=%h exp 1/%h", i, rx_valid, rx_data, exp_q[i]);
        miscompares++;
      end
      rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    end
    vectors++;
    if (rx_valid !== 1'b0 || ovf_cnt !== 8'd0) begin
      $display("FAIL filter_end rx_valid=%b ovf=%0d exp 0/0", rx_valid, ovf_cnt);
      miscompares++;
    end
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    vectors++;
    if (rx_valid !== 1'b0) begin
      $display("FAIL rx_ready_idle rx_valid=%b exp 0", rx_valid);
      miscompares++;
    end
  endtask

  task automatic test_err_pop;
    pop = 1'b1; tick(); pop = 1'b0;
    vectors++;
    if (err_pop !== 1'b1 || pndng !== 1'b0) begin
      $display("FAIL err_pop_set err_pop=%b pndng=%b exp 1/0", err_pop, pndng);
      miscompares++;
    end
    tick(); tick();
    vectors++;
    if (err_pop !== 1'b1 || pndng !== 1'b0) begin
      $display("FAIL err_pop_sticky err_pop=%b pndng=%b exp 1/0", err_pop, pndng);
      miscompares++;
    end
  endtask

  task automatic test_overflow;
    push = 1'b1; rx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      D_push = 16'h0300 + 16'(i); tick();
    end
    push = 1'b0;
    vectors++;
    if (rx_valid !== 1'b1 || ovf_cnt !== 8'd2 || rx_data !== 16'h0300) begin
      $display("FAIL ovf_full rx_valid=%b ovf=%0d head=%h exp 1/2/0300", rx_valid, ovf_cnt, rx_data);
      miscompares++;
    end
    // Full queue: push and read together, the push must land.
    push = 1'b1; D_push = 16'h03EE; rx_ready = 1'b1; tick();
    push = 1'b0; rx_ready = 1'b0;
    vectors++;
    if (ovf_cnt !== 8'd2 || rx_data !== 16'h0301) begin
      $display("FAIL full_pass ovf=%0d head=%h exp 2/0301", ovf_cnt, rx_data);
      miscompares++;
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = (i == 7) ? 16'h03EE : 16'h0301 + 16'(i);
      vectors++;
      if (rx_valid !== 1'b1 || rx_data !== e) begin
        $display("FAIL ovf_order[%0d] rx_valid=%b rx_data=%h exp 1/%h", i, rx_valid, rx_data, e);
        miscompares++;
      end
      rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    end
    vectors++;
    if (rx_valid !== 1'b0 || ovf_cnt !== 8'd2) begin
      $display("FAIL ovf_drained rx_valid=%b ovf=%0d exp 0/2", rx_valid, ovf_cnt);
      miscompares++;
    end
  endtask

  task automatic test_mid_reset;
    tx_valid = 1'b1; tx_data = 16'h3333;
    push = 1'b1; D_push = 16'h0344; tick();
    pop = 1'b1; rx_ready = 1'b1; tx_data = 16'h4444; D_push = 16'h0355;
    reset = 1'b0; tick();
    vectors++;
    if ({tx_ready, pndng, rx_valid, err_pop} !== 4'b1000 || ovf_cnt !== 8'd0) begin
      $display("FAIL mid_reset flags=%b ovf=%0d exp 1000/0", {tx_ready, pndng, rx_valid, err_pop}, ovf_cnt);
      miscompares++;
    end
    reset = 1'b1; idle_inputs(); tick();
    vectors++;
    if (pndng !== 1'b0 || rx_valid !== 1'b0) begin
      $display("FAIL post_reset pndng=%b rx_valid=%b exp 0/0", pndng, rx_valid);
      miscompares++;
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_tx_fwft();
    test_tx_full();
    test_back_to_back();
    test_filter();
    test_err_pop();
    test_overflow();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_terminal.md
BUS_TERMINAL -- requirements
Module: bus_terminal

Interface
REQ-001 SHALL have parameter pckg_sz, default 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] are the destination ID.
REQ-002 SHALL have parameter depth, default 8, entries per FIFO; power of two, at least 2.
REQ-003 SHALL have parameter id, default 0, this terminal's 8-bit address.
REQ-004 SHALL have parameter broadcast, default {8{1'b1}}, broadcast destination ID.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have port tx_valid, input, 1 bit, host offers a packet for the bus.
REQ-008 SHALL have port tx_data, input, pckg_sz bits, host packet.
REQ-009 SHALL have port tx_ready, output, 1 bit, TX FIFO not full.
REQ-010 SHALL have port pndng, output, 1 bit, TX FIFO not empty; this is the request to the bus arbiter.
REQ-011 SHALL have port D_pop, output, pckg_sz bits, TX FIFO head presented to the bus.
REQ-012 SHALL have port pop, input, 1 bit, arbiter consumes the TX head.
REQ-013 SHALL have port push, input, 1 bit, arbiter delivers a packet.
REQ-014 SHALL have port D_push, input, pckg_sz bits, delivered packet.
REQ-015 SHALL have port rx_valid, output, 1 bit, RX FIFO not empty.
REQ-016 SHALL have port rx_data, output, pckg_sz bits, RX FIFO head.
REQ-017 SHALL have port rx_ready, input, 1 bit, host consumes the RX head.
REQ-018 SHALL have port ovf_cnt, output, 8 bits, count of RX packets dropped because the RX FIFO was full.
REQ-019 SHALL have port err_pop, output, 1 bit, sticky flag: pop was received while the TX FIFO was empty.

Function
REQ-020 SHALL write TX on tx_valid && tx_ready; tx_ready = (tx_count < depth), from registered count only.
REQ-021 SHALL provide first-word-fall-through on both FIFOs: D_pop and rx_data equal the head in the same cycle the flag is high; the first write is visible the next cycle.
REQ-022 SHALL ignore pop while pndng=0 and SHALL set err_pop; FIFO state is unchanged.
REQ-023 SHALL accept simultaneous TX write and pop when not empty; the count is unchanged and pointers wrap modulo depth.
REQ-024 SHALL, on push, accept D_push only when its destination ID equals id or broadcast (see REQ-033).
REQ-025 SHALL store an accepted push if rx_count < depth, or if rx_count == depth and rx_ready is high in the same cycle (read frees space).
REQ-026 SHALL otherwise drop the push and increment ovf_cnt, saturating at 255.
REQ-027 SHALL ignore rx_ready while rx_valid=0.
REQ-028 SHALL never let a filtered-out push affect the FIFO or ovf_cnt.

Reset
REQ-029 SHALL, while reset=0 at posedge, clear pointers and counts, and drive tx_ready=1, pndng=0, rx_valid=0, ovf_cnt=0, err_pop=0.
REQ-030 SHALL ignore all handshakes in a reset cycle, and SHALL discard in-flight FIFO contents on reset asserted mid-operation.
REQ-031 SHALL keep D_pop and rx_data don't-care while the matching flag is 0.
REQ-032 SHALL have no asynchronous reset path.

Configuration
REQ-033 SHALL compile the destination filter only when macro BUS_TERMINAL_ADDR_FILTER_EN is defined; when it is undefined, every push is accepted regardless of ID.

Structure
REQ-034 SHALL place ID_W=8, the destination-ID field slice helper, and the broadcast default constant in shared package bus_pkg.
REQ-035 SHALL implement both queues as two instances of sub-module bus_fifo (parameters width and depth; ports wr, rd, din, dout, full, empty, count).

Verification
REQ-036 SHALL cover: host writes 16'h0155, 16'h0266 with no pop -> pndng=1 next cycle, D_pop=16'h0155; a pop then gives D_pop=16'h0266.
REQ-037 SHALL cover: with id=3 and the filter enabled, push 16'h03AA, 16'h04BB, 16'hFFCC -> rx_data sequence 16'h03AA, 16'hFFCC; 16'h04BB never appears.
REQ-038 SHALL cover: with depth=8, 8 matching pushes and then 2 more with rx_ready=0 -> rx_valid=1, ovf_cnt=2, first 8 packets preserved in order.
REQ-039 SHALL cover: pop with the TX FIFO empty -> err_pop=1 held until reset, pndng stays 0.
REQ-040 SHALL cover: RX full, push and rx_ready in the same cycle -> packet stored, ovf_cnt unchanged; then reset=0 for one cycle mid-stream -> all outputs at their REQ-029 values.
